// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point multiplier front-end:
// operand classes, flag bit positions and the canonical quiet NaN pattern.
package fp_pkg;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_SUB,
        FP_NORM,
        FP_INF,
        FP_QNAN,
        FP_SNAN
    } fp_class_e;

    localparam int FLG_INVALID = 2;
    localparam int FLG_INF     = 1;
    localparam int FLG_ZERO    = 0;

    // Canonical qNaN: sign 0, exponent all ones, only the mantissa MSB set.
    // Returned wide so any format up to 128 bits can truncate it.
    function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
        logic [127:0] r;
        r = ((128'(1) << exp_w) - 128'(1)) << man_w;
        r = r | (128'(1) << (man_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier. With flush-to-zero enabled a subnormal
// reports FP_ZERO; otherwise it reports FP_SUB and is multiplied normally.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter bit FTZ_EN    = 1'b1
) (
    input  logic [EXP_WIDTH+MAN_WIDTH:0] operand,
    output logic [2:0]                   cls,
    output logic                         sign
);

    logic [EXP_WIDTH-1:0] exp_f;
    logic [MAN_WIDTH-1:0] man_f;
    fp_class_e            cls_e;

    assign exp_f = operand[EXP_WIDTH+MAN_WIDTH-1:MAN_WIDTH];
    assign man_f = operand[MAN_WIDTH-1:0];
    assign sign  = operand[EXP_WIDTH+MAN_WIDTH];

    always_comb begin
        cls_e = FP_NORM;
        if (exp_f == {EXP_WIDTH{1'b1}}) begin
            if (man_f == '0)
                cls_e = FP_INF;
            else if (man_f[MAN_WIDTH-1])
                cls_e = FP_QNAN;
            else
                cls_e = FP_SNAN;
        end else if (exp_f == '0) begin
            if (man_f == '0)
                cls_e = FP_ZERO;
            else
                cls_e = FTZ_EN ? FP_ZERO : FP_SUB;
        end
    end

    assign cls = cls_e;

endmodule

// File: rtl/fp_mul_exception_pipe.sv
// Registered exception front-end for the FP multiplier: resolves NaN/Inf/Zero
// operand combinations to a final result, or requests the normal multiply path.
module fp_mul_exception_pipe
    import fp_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MAN_WIDTH  = 23,
    parameter int DATA_WIDTH = EXP_WIDTH + MAN_WIDTH + 1,
    parameter bit FTZ_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] float_num1,
    input  logic [DATA_WIDTH-1:0] float_num2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel,
    output logic [DATA_WIDTH-1:0] out,
    output logic [2:0]            flags,
    output logic [2:0]            sticky_flags,
    input  logic                  flag_clr
);

    localparam logic [DATA_WIDTH-1:0] QNAN = DATA_WIDTH'(fp_qnan(EXP_WIDTH, MAN_WIDTH));

    logic [DATA_WIDTH-1:0] opnd      [2];
    logic [2:0]            cls_raw   [2];
    fp_class_e             cls_e     [2];
    logic                  sign_v    [2];

    logic                  out_valid_reg;
    logic                  sel_reg;
    logic [DATA_WIDTH-1:0] out_reg;
    logic [2:0]            flags_reg;
    logic [2:0]            sticky_reg;

    logic                  sel_next;
    logic [DATA_WIDTH-1:0] out_next;
    logic [2:0]            flags_next;

    logic                  accept;
    logic                  res_sign;
    logic                  any_nan, any_snan, any_inf, any_zero;

    assign opnd[0] = float_num1;
    assign opnd[1] = float_num2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cls
            fp_classify #(
                .EXP_WIDTH (EXP_WIDTH),
                .MAN_WIDTH (MAN_WIDTH),
                .FTZ_EN    (FTZ_EN)
            ) u_classify (
                .operand (opnd[gi]),
                .cls     (cls_raw[gi]),
                .sign    (sign_v[gi])
            );
            assign cls_e[gi] = fp_class_e'(cls_raw[gi]);
        end
    endgenerate

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign res_sign = sign_v[0] ^ sign_v[1];

    assign any_snan = (cls_e[0] == FP_SNAN) || (cls_e[1] == FP_SNAN);
    assign any_nan  = any_snan || (cls_e[0] == FP_QNAN) || (cls_e[1] == FP_QNAN);
    assign any_inf  = (cls_e[0] == FP_INF)  || (cls_e[1] == FP_INF);
    assign any_zero = (cls_e[0] == FP_ZERO) || (cls_e[1] == FP_ZERO);

    // Ordered priority: NaN, then Inf*0, then Inf, then Zero, else compute.
    always_comb begin
        sel_next   = 1'b0;
        out_next   = '0;
        flags_next = '0;
        if (any_nan) begin
            out_next                = QNAN;
            flags_next[FLG_INVALID] = any_snan;
        end else if (any_inf && any_zero) begin
            out_next                = QNAN;
            flags_next[FLG_INVALID] = 1'b1;
        end else if (any_inf) begin
            out_next            = {res_sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
            flags_next[FLG_INF] = 1'b1;
        end else if (any_zero) begin
            out_next             = {res_sign, {(DATA_WIDTH-1){1'b0}}};
            flags_next[FLG_ZERO] = 1'b1;
        end else begin
            sel_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            sel_reg       <= 1'b0;
            out_reg       <= '0;
            flags_reg     <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            sel_reg       <= sel_next;
            out_reg       <= out_next;
            flags_reg     <= flags_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // A clear coinciding with an accept keeps the new event's flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_reg <= '0;
        else if (accept)
            sticky_reg <= flag_clr ? flags_next : (sticky_reg | flags_next);
        else if (flag_clr)
            sticky_reg <= '0;
    end

    assign out_valid    = out_valid_reg;
    assign sel          = sel_reg;
    assign out          = out_reg;
    assign flags        = flags_reg;
    assign sticky_flags = sticky_reg;

endmodule

// File: tb/tb_fp_mul_exception_pipe.sv
// Directed checks of fp_mul_exception_pipe (FTZ on and off), back-pressure,
// sticky flags, asynchronous reset, plus a scoreboarded random stream.
module tb_fp_mul_exception_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        flag_clr;
    logic [31:0] a, b;

    logic        in_ready, out_valid, sel;
    logic [31:0] out;
    logic [2:0]  flags, sticky_flags;

    logic        nf_in_ready, nf_out_valid, nf_sel;
    logic [31:0] nf_out;
    logic [2:0]  nf_flags, nf_sticky_flags;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp_mul_exception_pipe #(.EXP_WIDTH(8), .MAN_WIDTH(23), .FTZ_EN(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .float_num1   (a),
        .float_num2   (b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sel          (sel),
        .out          (out),
        .flags        (flags),
        .sticky_flags (sticky_flags),
        .flag_clr     (flag_clr)
    );

    fp_mul_exception_pipe #(.EXP_WIDTH(8), .MAN_WIDTH(23), .FTZ_EN(1'b0)) dut_nf (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (nf_in_ready),
        .float_num1   (a),
        .float_num2   (b),
        .out_valid    (nf_out_valid),
        .out_ready    (out_ready),
        .sel          (nf_sel),
        .out          (nf_out),
        .flags        (nf_flags),
        .sticky_flags (nf_sticky_flags),
        .flag_clr     (flag_clr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else begin
            n_pass++;
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Offer one pair with out_ready=1; check the registered result a cycle later.
    task automatic xfer(input logic [31:0] ta, input logic [31:0] tb_v, input logic esel,
                        input logic [31:0] eout, input logic [2:0] eflg, input string tag);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " valid"}, 64'(out_valid), 64'(1));
        check({tag, " sel"},   64'(sel),       64'(esel));
        check({tag, " out"},   64'(out),       64'(eout));
        check({tag, " flags"}, 64'(flags),     64'(eflg));
    endtask

    // Independent reference for the FTZ=1, binary32 instance: {sel, out, flags}.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        logic xn, xs, xi, xz, yn, ys, yi, yz, s;
        s  = x[31] ^ y[31];
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
        xs = xn && !x[22];
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
        xz = (x[30:23] == 8'h00);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
        ys = yn && !y[22];
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
        yz = (y[30:23] == 8'h00);
        if (xn || yn)                 return {1'b0, 32'h7FC00000, (xs || ys), 2'b00};
        if ((xi && yz) || (yi && xz)) return {1'b0, 32'h7FC00000, 3'b100};
        if (xi || yi)                 return {1'b0, s, 8'hFF, 23'h0, 3'b010};
        if (xz || yz)                 return {1'b0, s, 31'h0, 3'b001};
        return {1'b1, 32'h0, 3'b000};
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] pool [10];
        int idx;
        pool = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                 32'h7F800001, 32'hFFA00000, 32'h00000001, 32'h3F800000, 32'hC0400000};
        idx = $urandom_range(0, 13);
        if (idx >= 10) return $urandom();
        return pool[idx];
    endfunction

    initial begin
        logic [35:0] q [$];
        logic [35:0] exp_v;
        int acc;
        int cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flag_clr  = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        check("rst out_valid", 64'(out_valid),    64'(0));
        check("rst sel",       64'(sel),          64'(0));
        check("rst out",       64'(out),          64'(0));
        check("rst flags",     64'(flags),        64'(0));
        check("rst sticky",    64'(sticky_flags), 64'(0));
        check("rst in_ready",  64'(in_ready),     64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(32'h40400000, 32'hC0000000, 1'b1, 32'h00000000, 3'b000, "3*-2");
        xfer(32'h80000000, 32'h3F800000, 1'b0, 32'h80000000, 3'b001, "-0*1");
        xfer(32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 3'b010, "-inf*2");
        xfer(32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 3'b100, "inf*0");
        xfer(32'h00000000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, "0*-inf");
        xfer(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, "snan*1");
        xfer(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000, "qnan*1");
        xfer(32'h7FC00000, 32'h00000000, 1'b0, 32'h7FC00000, 3'b000, "qnan*0");
        xfer(32'h80000001, 32'h40000000, 1'b0, 32'h80000000, 3'b001, "-sub*2 ftz");
        xfer(32'h00000001, 32'h40000000, 1'b0, 32'h00000000, 3'b001, "sub*2 ftz");
        check("sub*2 noftz sel", 64'(nf_sel), 64'(1));
        check("sub*2 noftz out", 64'(nf_out), 64'(0));
        check("sticky accum",    64'(sticky_flags), 64'(3'b111));

        // Clear and an accept in the same cycle: the new event survives.
        a = 32'h7F800000; b = 32'h40000000; in_valid = 1'b1; flag_clr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flag_clr = 1'b0;
        check("clr+inf sticky", 64'(sticky_flags), 64'(3'b010));
        check("clr+inf out",    64'(out),          64'(32'h7F800000));
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        check("clr alone sticky", 64'(sticky_flags), 64'(0));

        // Back-pressure: second operand pair waits for out_ready.
        out_ready = 1'b0;
        a = 32'h80000000; b = 32'h3F800000; in_valid = 1'b1;
        @(negedge clk);
        check("bp first valid", 64'(out_valid), 64'(1));
        check("bp first out",   64'(out),       64'(32'h80000000));
        a = 32'hFF800000; b = 32'h40000000;
        #1;
        check("bp in_ready low", 64'(in_ready), 64'(0));
        @(negedge clk);
        check("bp held out",   64'(out),      64'(32'h80000000));
        check("bp held flags", 64'(flags),    64'(3'b001));
        check("bp held valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        #1;
        check("bp in_ready high", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        check("bp second out",   64'(out),   64'(32'hFF800000));
        check("bp second flags", 64'(flags), 64'(3'b010));
        @(negedge clk);
        check("bp drained valid", 64'(out_valid), 64'(0));

        // Random stream with random stalls against the reference model.
        acc = 0;
        cyc = 0;
        while ((acc < 100 || q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0) || (acc >= 100);
            if (acc < 100) begin
                in_valid = 1'($urandom_range(0, 1));
                a        = pick();
                b        = pick();
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                check("rnd pending", 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) begin
                    exp_v = q.pop_front();
                    check("rnd result", 64'({sel, out, flags}), 64'(exp_v));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b));
                acc++;
            end
        end
        check("rnd accepted", 64'(acc), 64'(100));
        check("rnd drained",  64'(q.size()), 64'(0));

        // Asynchronous reset while a result is held.
        @(negedge clk);
        out_ready = 1'b0;
        a = 32'h7F800000; b = 32'hBF800000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre-rst valid", 64'(out_valid), 64'(1));
        check("pre-rst out",   64'(out),       64'(32'hFF800000));
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst valid",  64'(out_valid),    64'(0));
        check("async rst out",    64'(out),          64'(0));
        check("async rst sticky", 64'(sticky_flags), 64'(0));
        check("async rst ready",  64'(in_ready),     64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_mul_exception_pipe.md
Name: fp_mul_exception_pipe

Overview:
Registered, parametrised exception front-end for the floating-point multiplier. It classifies both operands and, for special cases, produces the final IEEE-754 result directly; otherwise it tells the datapath to compute. Compared with the combinational 32-bit handler it adds:
- generic exponent/mantissa widths;
- signed zero/inf handling, NaN and inf*0 handling, optional flush-to-zero;
- a one-deep valid/ready output register;
- sticky exception flags.

Parameters:
EXP_WIDTH, 8, exponent field width
MAN_WIDTH, 23, stored mantissa width
DATA_WIDTH, EXP_WIDTH+MAN_WIDTH+1, operand/result width (derived; do not override)
FTZ_EN, 1, 1 = subnormal operands are treated as zero of the same sign

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
float_num1  input  DATA_WIDTH  operand A
float_num2  input  DATA_WIDTH  operand B
out_valid  output  1  result register valid
out_ready  input  1  downstream accepts result
sel  output  1  1 = normal multiply path required; 0 = out is final
out  output  DATA_WIDTH  special-case result (all zeros when sel=1)
flags  output  3  {invalid, inf_result, zero_result} for the current out
sticky_flags  output  3  OR-accumulation of flags since reset/clear
flag_clr  input  1  synchronous clear of sticky_flags

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, sel=0, out=0, flags=0, sticky_flags=0. Reset mid-transfer discards the held result.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready; the result appears next cycle with out_valid=1. Latency is 1.
  - Result and out_valid are held stable while out_valid && !out_ready.
  - Back-to-back accepts sustain 1 result/cycle when out_ready=1.
  - out_valid clears after a transfer with no new accept.
- Per-operand classification:
  - exp==all-ones, man!=0 -> NaN. Signalling if man MSB==0.
  - exp==all-ones, man==0 -> Inf.
  - exp==0, man==0 -> Zero.
  - exp==0, man!=0 -> Sub. Sub counts as Zero when FTZ_EN=1, otherwise as Normal.
- Result sign s = sign1 ^ sign2. Canonical qNaN = sign 0, exp all-ones, man MSB 1, rest 0 (0x7FC00000 at defaults).
- Priority, first match wins:
  1. Either operand NaN -> out=qNaN, sel=0, invalid=1 if either NaN is signalling.
  2. Inf*Zero (either order) -> out=qNaN, sel=0, invalid=1.
  3. Either operand Inf -> out={s, all-ones, 0}, sel=0, inf_result=1.
  4. Either operand Zero -> out={s, 0, 0}, sel=0, zero_result=1.
  5. Otherwise -> out=0, sel=1, flags=0.
- flags are registered together with out and describe only the held result.
- sticky_flags:
  - OR-updated with new flags on each accepted input (the same cycle the result register loads).
  - flag_clr clears it.
  - If flag_clr and an accept occur in the same cycle, sticky_flags = new flags only (the new event wins).
- Inputs are ignored when !(in_valid && in_ready).

Decomposition:
- Shared package fp_pkg holds:
  - class enum {FP_ZERO, FP_SUB, FP_NORM, FP_INF, FP_QNAN, FP_SNAN};
  - flag bit indices FLG_INVALID=2, FLG_INF=1, FLG_ZERO=0;
  - a canonical-qNaN constant function of EXP_WIDTH/MAN_WIDTH.
- One sub-module, fp_classify: combinational, parametrised by EXP_WIDTH/MAN_WIDTH/FTZ_EN, returns class and sign. Instantiate it twice.
- The top level holds the priority logic, the output register and the sticky flags.

Test Plan:
- Reset, then in_valid=1 with A=0x40400000 (3.0), B=0xC0000000 (-2.0), out_ready=1 -> next cycle out_valid=1, sel=1, out=0x00000000, flags=000.
- A=0x80000000, B=0x3F800000 -> sel=0, out=0x80000000, flags=001. Then A=0xFF800000, B=0x40000000 -> out=0xFF800000, flags=010.
- A=0x7F800000, B=0x00000000 -> out=0x7FC00000, invalid=1. A=0x7F800001 (sNaN), B=0x3F800000 -> out=0x7FC00000, invalid=1. A=0x7FC00000, B=1.0 -> out=0x7FC00000, invalid=0.
- FTZ_EN=1: A=0x00000001, B=0x40000000 -> out=0x00000000, zero_result=1. FTZ_EN=0: same operands -> sel=1.
- Back-pressure: out_ready=0 with two offered inputs -> first result held stable, in_ready=0, second accepted only in the cycle out_ready rises; no loss or duplication over 100 random pairs checked against a reference model.
- Sticky: invalid event, then flag_clr asserted in the same cycle as an Inf*2 accept -> sticky_flags=010. Assert rst_n low while out_valid=1 -> out_valid=0 immediately.
